// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIfRd,
    StLsRd,
    StLsWr
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Size 2'b11 is treated as a word, same as SZ_W.
  function automatic logic [2:0] size_to_beats(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io_region(input logic [1:0] region_bits);
    return region_bits == 2'b11;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and RAM-side signals of the memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;
  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_done, if_data,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output ls_done, ls_rdata,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr, busy
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_done, if_data,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  ls_done, ls_rdata,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr, busy
  );

endinterface

// File: rtl/mem_byte_assembler.sv
// Collects read bytes into a 32-bit word by beat index; cleared when an access starts.
module mem_byte_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [1:0]  idx_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] data_o
);

  logic [31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (capture_i) begin
      data_d[{idx_i, 3'b000} +: 8] = byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_d;
    end
  end

  // Includes this cycle's capture so the final byte is visible in the completion cycle.
  assign data_o = data_d;

endmodule

// File: rtl/mem_arbiter.sv
// Single byte-wide RAM port arbiter: LS has priority over IF, accesses are serialised into
// byte beats, and fetches can be aborted by a branch flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IO_BIT = 17
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  mem_arbiter_if.slave   bus
);

  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [2:0]        beats_q, beats_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;
  logic              busy_q, busy_d;

  logic              ls_io_blocked, ls_accept, if_accept;
  logic              asm_clear, asm_capture;
  logic [31:0]       asm_data;
  logic [ADDR_W-1:0] next_addr;
  logic [1:0]        next_idx, cap_idx;

  assign ls_io_blocked = bus.ls_we && bus.io_buffer_full &&
                         is_io_region(bus.ls_addr[IO_BIT:IO_BIT-1]);
  assign ls_accept     = bus.ls_req && !ls_done_q && !ls_io_blocked;
  assign if_accept     = bus.if_req && !if_done_q && !bus.if_flush;

  assign next_addr = addr_q + ADDR_W'(count_q) + ADDR_W'(1);
  assign next_idx  = count_q[1:0] + 2'd1;
  // Reads capture one cycle behind the issued address.
  assign cap_idx   = count_q[1:0] - 2'd1;

  mem_byte_assembler u_assembler (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .en_i      (rdy_in),
    .clear_i   (asm_clear),
    .capture_i (asm_capture),
    .idx_i     (cap_idx),
    .byte_i    (bus.mem_din),
    .data_o    (asm_data)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    beats_d     = beats_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    wr_d        = wr_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_data_d   = if_data_q;
    ls_rdata_d  = ls_rdata_q;
    asm_clear   = 1'b0;
    asm_capture = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ls_accept) begin
          state_d   = bus.ls_we ? StLsWr : StLsRd;
          beats_d   = size_to_beats(bus.ls_size);
          addr_d    = bus.ls_addr;
          mem_a_d   = bus.ls_addr;
          wdata_d   = bus.ls_wdata;
          count_d   = 3'd0;
          asm_clear = 1'b1;
          if (bus.ls_we) begin
            wr_d       = 1'b1;
            mem_dout_d = bus.ls_wdata[7:0];
          end
        end else if (if_accept) begin
          state_d   = StIfRd;
          beats_d   = 3'd4;
          addr_d    = bus.if_addr;
          mem_a_d   = bus.if_addr;
          count_d   = 3'd0;
          asm_clear = 1'b1;
        end
      end

      StIfRd, StLsRd: begin
        if (state_q == StIfRd && bus.if_flush) begin
          state_d = StIdle;
          count_d = 3'd0;
        end else begin
          asm_capture = (count_q != 3'd0);
          if (count_q == beats_q) begin
            state_d = StIdle;
            count_d = 3'd0;
            if (state_q == StIfRd) begin
              if_done_d = 1'b1;
              if_data_d = asm_data;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = asm_data;
            end
          end else begin
            count_d = count_q + 3'd1;
            if ((count_q + 3'd1) < beats_q) begin
              mem_a_d = next_addr;
            end
          end
        end
      end

      StLsWr: begin
        if (count_q == beats_q - 3'd1) begin
          state_d   = StIdle;
          count_d   = 3'd0;
          wr_d      = 1'b0;
          ls_done_d = 1'b1;
        end else begin
          count_d    = count_q + 3'd1;
          mem_a_d    = next_addr;
          mem_dout_d = wdata_q[{next_idx, 3'b000} +: 8];
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      count_q    <= '0;
      beats_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      count_q    <= count_d;
      beats_q    <= beats_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      wr_q       <= wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = wr_q & rdy_in;
  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions and write beats are queued with the
// cycle they must appear in, and a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned RamSize = 262144;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  bit [7:0]  ram [RamSize];
  done_exp_t if_exp[$];
  done_exp_t ls_exp[$];
  wr_exp_t   wr_exp[$];

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W (32),
    .IO_BIT (17)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // RAM model with 1-cycle read latency, clock-enabled by rdy like the rest of the system.
  initial begin
    logic [17:0] idx;
    logic [7:0]  rd;
    bus.mem_din = 8'h00;
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05;
    ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h00;
    ram[18'h00300] = 8'h80;
    ram[18'h00400] = 8'h93; ram[18'h00401] = 8'h00;
    ram[18'h00402] = 8'h10; ram[18'h00403] = 8'h00;
    ram[18'h00500] = 8'h11; ram[18'h00501] = 8'h22;
    ram[18'h00502] = 8'h33; ram[18'h00503] = 8'h44;
    forever begin
      @(posedge clk);
      if (rdy) begin
        idx = bus.mem_a[17:0];
        rd  = ram[idx];
        if (bus.mem_wr) ram[idx] = bus.mem_dout;
        bus.mem_din <= rd;
      end
    end
  end

  always @(negedge clk) begin
    done_exp_t e;
    wr_exp_t   w;
    if (bus.if_done) begin
      if (if_exp.size() == 0) begin
        check_eq("if_done_pending", 32'(if_exp.size()), 32'd1);
      end else begin
        e = if_exp.pop_front();
        check_eq("if_data", bus.if_data, e.data);
        check_eq("if_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus.ls_done) begin
      if (ls_exp.size() == 0) begin
        check_eq("ls_done_pending", 32'(ls_exp.size()), 32'd1);
      end else begin
        e = ls_exp.pop_front();
        if (e.chk) check_eq("ls_rdata", bus.ls_rdata, e.data);
        check_eq("ls_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus.mem_wr) begin
      if (wr_exp.size() == 0) begin
        check_eq("wr_pending", 32'(wr_exp.size()), 32'd1);
      end else begin
        w = wr_exp.pop_front();
        check_eq("wr_addr", bus.mem_a, w.addr);
        check_eq("wr_data", 32'(bus.mem_dout), 32'(w.data));
        check_eq("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.if_done) seen = 1'b1;
    end
    check_eq("if_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_ls(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.ls_done) seen = 1'b1;
    end
    check_eq("ls_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    if_exp.push_back('{data: data, cyc: cyc + 6, chk: 1'b1});
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    wait_if(20);
    tick();
    bus.if_req = 1'b0;
  endtask

  initial begin
    int c;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = SZ_B;
    bus.ls_addr = '0; bus.ls_wdata = '0; bus.io_buffer_full = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_a", bus.mem_a, 32'h0);
    check_eq("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
    check_eq("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
    check_eq("rst_if_done", 32'(bus.if_done), 32'h0);
    check_eq("rst_ls_done", 32'(bus.ls_done), 32'h0);
    check_eq("rst_if_data", bus.if_data, 32'h0);
    check_eq("rst_ls_rdata", bus.ls_rdata, 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    tick();
    rst = 1'b0;

    // Plain fetch.
    do_fetch(32'h100, 32'h0000_0513);

    // Halfword write.
    c = cyc;
    wr_exp.push_back('{addr: 32'h200, data: 8'hDD, cyc: c + 1});
    wr_exp.push_back('{addr: 32'h201, data: 8'hCC, cyc: c + 2});
    ls_exp.push_back('{data: 32'h0, cyc: c + 3, chk: 1'b0});
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = SZ_H;
    bus.ls_addr = 32'h200; bus.ls_wdata = 32'hAABB_CCDD;
    wait_ls(20);
    tick();
    bus.ls_req = 1'b0;
    check_eq("if_data_hold", bus.if_data, 32'h0000_0513);

    // Simultaneous requests: LS byte read first, IF accepted in the ls_done cycle.
    c = cyc;
    ls_exp.push_back('{data: 32'h0000_0080, cyc: c + 3, chk: 1'b1});
    if_exp.push_back('{data: 32'h0000_0513, cyc: c + 9, chk: 1'b1});
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SZ_B; bus.ls_addr = 32'h300;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    wait_ls(20);
    tick();
    bus.ls_req = 1'b0;
    wait_if(20);
    tick();
    bus.if_req = 1'b0;

    // Flush mid-fetch, then a fresh fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    repeat (3) tick();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    tick();
    bus.if_flush = 1'b0;
    @(negedge clk);
    check_eq("flush_idle", 32'(bus.busy), 32'h0);
    tick();
    do_fetch(32'h400, 32'h0010_0093);

    // Flush in the last capture cycle must still suppress completion.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    repeat (5) tick();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    tick();
    bus.if_flush = 1'b0;
    @(negedge clk);
    check_eq("flush_last_idle", 32'(bus.busy), 32'h0);
    check_eq("flush_last_keep", bus.if_data, 32'h0010_0093);
    tick();

    // IO write held off by io_buffer_full for 5 cycles.
    c = cyc;
    bus.io_buffer_full = 1'b1;
    wr_exp.push_back('{addr: 32'h3_0000, data: 8'h77, cyc: c + 6});
    ls_exp.push_back('{data: 32'h0, cyc: c + 7, chk: 1'b0});
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = SZ_B;
    bus.ls_addr = 32'h3_0000; bus.ls_wdata = 32'h0000_0077;
    repeat (5) tick();
    bus.io_buffer_full = 1'b0;
    wait_ls(20);
    tick();
    bus.ls_req = 1'b0;

    // Word read with a 3-cycle rdy stall.
    c = cyc;
    ls_exp.push_back('{data: 32'h4433_2211, cyc: c + 9, chk: 1'b1});
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SZ_W; bus.ls_addr = 32'h500;
    repeat (2) tick();
    rdy = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    wait_ls(20);
    tick();
    bus.ls_req = 1'b0;

    // Reset in the middle of a word write.
    c = cyc;
    wr_exp.push_back('{addr: 32'h600, data: 8'h78, cyc: c + 1});
    wr_exp.push_back('{addr: 32'h601, data: 8'h56, cyc: c + 2});
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = SZ_W;
    bus.ls_addr = 32'h600; bus.ls_wdata = 32'h1234_5678;
    repeat (2) tick();
    rst = 1'b1;
    bus.ls_req = 1'b0;
    tick();
    @(negedge clk);
    check_eq("rst_mid_wr_low", 32'(bus.mem_wr), 32'h0);
    check_eq("rst_mid_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_mid_rdata", bus.ls_rdata, 32'h0);
    tick();
    rst = 1'b0;
    repeat (10) tick();

    check_eq("if_exp_left", 32'(if_exp.size()), 32'd0);
    check_eq("ls_exp_left", 32'(ls_exp.size()), 32'd0);
    check_eq("wr_exp_left", 32'(wr_exp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
